// File: rtl/rate_counter_pkg.sv
// Shared types and divider-load arithmetic for the rate-divided counter.
package rate_counter_pkg;

    typedef enum logic [1:0] {
        SPD_FULL = 2'd0,
        SPD_4HZ  = 2'd1,
        SPD_2HZ  = 2'd2,
        SPD_1HZ  = 2'd3
    } speed_t;

    // A rate of 0 means step on every clock, so the divider never leaves 0.
    function automatic int unsigned calc_load(input int unsigned clk_hz,
                                              input int unsigned rate_hz,
                                              input int unsigned sim_div);
        if (rate_hz == 0) begin
            return 0;
        end
        return clk_hz / (rate_hz * sim_div) - 1;
    endfunction

endpackage

// File: rtl/rate_tick_gen.sv
// Down-counting rate divider producing the step-enable tick for the counter.
module rate_tick_gen
    import rate_counter_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50000000,
    parameter int unsigned SIM_DIV  = 1,
    parameter int unsigned RATE0_HZ = 0,
    parameter int unsigned RATE1_HZ = 4,
    parameter int unsigned RATE2_HZ = 2,
    parameter int unsigned RATE3_HZ = 1,
    parameter int          DIV_W    = 26
) (
    input  logic   clock,
    input  logic   reset,
    input  logic   run,
    input  logic   load,
    input  speed_t speed_sel,
    output logic   tick
);

    localparam logic [DIV_W-1:0] LOAD_0 = DIV_W'(calc_load(CLK_HZ, RATE0_HZ, SIM_DIV));
    localparam logic [DIV_W-1:0] LOAD_1 = DIV_W'(calc_load(CLK_HZ, RATE1_HZ, SIM_DIV));
    localparam logic [DIV_W-1:0] LOAD_2 = DIV_W'(calc_load(CLK_HZ, RATE2_HZ, SIM_DIV));
    localparam logic [DIV_W-1:0] LOAD_3 = DIV_W'(calc_load(CLK_HZ, RATE3_HZ, SIM_DIV));

    speed_t           speed_sel_q;
    logic [DIV_W-1:0] div;
    logic [DIV_W-1:0] load_sel;
    logic             spd_change;

    // Indexed by the live select: it equals speed_sel_q whenever the divider
    // reloads at terminal count, and is the new rate on a speed change.
    always_comb begin
        load_sel = LOAD_0;
        case (speed_sel)
            SPD_FULL: load_sel = LOAD_0;
            SPD_4HZ:  load_sel = LOAD_1;
            SPD_2HZ:  load_sel = LOAD_2;
            SPD_1HZ:  load_sel = LOAD_3;
            default:  load_sel = LOAD_0;
        endcase
    end

    assign spd_change = (speed_sel != speed_sel_q);
    assign tick       = run && (div == '0) && !load && !spd_change;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div         <= LOAD_0;
            speed_sel_q <= SPD_FULL;
        end else begin
            speed_sel_q <= speed_sel;
            if (load || spd_change) begin
                div <= load_sel;
            end else if (run) begin
                div <= (div == '0) ? load_sel : div - DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/rate_counter.sv
// Up/down counter stepping at a selectable divided rate, with load, pause,
// wrap/saturate limits and a one-cycle terminal-count flag.
module rate_counter
    import rate_counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int          MAX_COUNT = 2**WIDTH - 1,
    parameter int unsigned CLK_HZ    = 50000000,
    parameter int unsigned SIM_DIV   = 1,
    parameter int unsigned RATE0_HZ  = 0,
    parameter int unsigned RATE1_HZ  = 4,
    parameter int unsigned RATE2_HZ  = 2,
    parameter int unsigned RATE3_HZ  = 1,
    parameter int          DIV_W     = 26
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [1:0]       speed_sel,
    input  logic             run,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             wrap,
    output logic [WIDTH-1:0] count,
    output logic             tick,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);

    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;

    rate_tick_gen #(
        .CLK_HZ   (CLK_HZ),
        .SIM_DIV  (SIM_DIV),
        .RATE0_HZ (RATE0_HZ),
        .RATE1_HZ (RATE1_HZ),
        .RATE2_HZ (RATE2_HZ),
        .RATE3_HZ (RATE3_HZ),
        .DIV_W    (DIV_W)
    ) u_tick_gen (
        .clock     (clock),
        .reset     (reset),
        .run       (run),
        .load      (load),
        .speed_sel (speed_t'(speed_sel)),
        .tick      (tick)
    );

    // tc flags only a step onto the terminal value, never a wrap off it
    // or a saturated hold.
    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        if (load) begin
            count_nxt = (load_value > MAX_C) ? MAX_C : load_value;
        end else if (tick) begin
            if (up) begin
                if (count == MAX_C) begin
                    count_nxt = wrap ? '0 : count;
                end else begin
                    count_nxt = count + WIDTH'(1);
                    tc_nxt    = (count_nxt == MAX_C);
                end
            end else begin
                if (count == '0) begin
                    count_nxt = wrap ? MAX_C : count;
                end else begin
                    count_nxt = count - WIDTH'(1);
                    tc_nxt    = (count_nxt == '0);
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
        end
    end

endmodule
